// File: rtl/axi_stream_frame_sorter.sv
// Frame sorter: buffers one vld/sof/eof frame, sorts its keys ascending with an
// odd-even transposition network, then re-emits the frame in the same format.
module axi_stream_frame_sorter #(
  parameter int DATA_WIDTH = 64,
  parameter int KEY_WIDTH  = 16,
  parameter int MAX_WORDS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vld,
  input  logic                  sof,
  input  logic                  eof,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  vld_o,
  output logic                  sof_o,
  output logic                  eof_o,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  busy,
  output logic [7:0]            drop_cnt,
  output logic                  err
);

  localparam int L      = DATA_WIDTH / KEY_WIDTH;
  localparam int NKEYS  = MAX_WORDS * L;
  localparam int KIDX_W = (NKEYS > 1) ? $clog2(NKEYS) : 1;
  localparam int CNT_W  = $clog2(MAX_WORDS + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_SORT, ST_SEND} state_t;

  state_t                state_r;
  logic [KEY_WIDTH-1:0]  keys_r   [NKEYS];
  logic [KEY_WIDTH-1:0]  sorted_s [NKEYS];
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      send_idx_r;
  logic [KIDX_W-1:0]     sort_r;
  logic [DATA_WIDTH-1:0] send_word_s;
  logic                  vld_o_r, sof_o_r, eof_o_r, busy_r, err_r;
  logic [DATA_WIDTH-1:0] dout_r;
  logic [7:0]            drop_r;

  function automatic logic [KIDX_W-1:0] key_idx(input int word, input int lane);
    return KIDX_W'(word * L + lane);
  endfunction

  // One transposition step: even pairs on even steps, odd pairs on odd steps.
  always_comb begin
    sorted_s = keys_r;
    for (int i = 0; i < NKEYS; i++) begin
      if ((i < NKEYS - 1) && (((i % 2) == 1) == sort_r[0])) begin
        sorted_s[i] = (keys_r[i] > keys_r[(i + 1) % NKEYS]) ? keys_r[(i + 1) % NKEYS] : keys_r[i];
      end else if ((i > 0) && ((((i + NKEYS - 1) % 2) == 1) == sort_r[0])) begin
        sorted_s[i] = (keys_r[(i + NKEYS - 1) % NKEYS] > keys_r[i]) ? keys_r[(i + NKEYS - 1) % NKEYS] : keys_r[i];
      end else begin
        sorted_s[i] = keys_r[i];
      end
    end
  end

  // Gathers the lanes of the word currently being sent.
  always_comb begin
    send_word_s = '0;
    for (int k = 0; k < L; k++) begin
      send_word_s[k*KEY_WIDTH +: KEY_WIDTH] = keys_r[key_idx(int'(send_idx_r), k)];
    end
  end

  // Frame capture, sort sequencing, output emission and drop accounting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      send_idx_r <= '0;
      sort_r     <= '0;
      vld_o_r    <= 1'b0;
      sof_o_r    <= 1'b0;
      eof_o_r    <= 1'b0;
      dout_r     <= '0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
      drop_r     <= 8'd0;
      for (int i = 0; i < NKEYS; i++) keys_r[i] <= '1;
    end else begin
      err_r   <= 1'b0;
      vld_o_r <= 1'b0;
      sof_o_r <= 1'b0;
      eof_o_r <= 1'b0;
      dout_r  <= '0;
      if ((state_r == ST_SORT || state_r == ST_SEND) && vld && sof && (drop_r != 8'hFF)) begin
        drop_r <= drop_r + 8'd1;
      end
      case (state_r)
        ST_IDLE: begin
          if (vld && sof) begin
            for (int k = 0; k < L; k++) keys_r[key_idx(0, k)] <= din[k*KEY_WIDTH +: KEY_WIDTH];
            cnt_r   <= CNT_W'(1);
            sort_r  <= '0;
            busy_r  <= eof;
            state_r <= eof ? ST_SORT : ST_RECV;
          end
        end
        ST_RECV: begin
          if (vld) begin
            if (sof) begin
              // Restart: later word-0 writes override the all-ones refill.
              for (int i = 0; i < NKEYS; i++) keys_r[i] <= '1;
              for (int k = 0; k < L; k++) keys_r[key_idx(0, k)] <= din[k*KEY_WIDTH +: KEY_WIDTH];
              cnt_r   <= CNT_W'(1);
              err_r   <= 1'b1;
              busy_r  <= eof;
              state_r <= eof ? ST_SORT : ST_RECV;
            end else if (cnt_r == CNT_W'(MAX_WORDS)) begin
              for (int i = 0; i < NKEYS; i++) keys_r[i] <= '1;
              cnt_r   <= '0;
              err_r   <= 1'b1;
              state_r <= ST_IDLE;
            end else begin
              for (int k = 0; k < L; k++) keys_r[key_idx(int'(cnt_r), k)] <= din[k*KEY_WIDTH +: KEY_WIDTH];
              cnt_r   <= cnt_r + CNT_W'(1);
              busy_r  <= eof;
              state_r <= eof ? ST_SORT : ST_RECV;
            end
          end
        end
        ST_SORT: begin
          keys_r <= sorted_s;
          sort_r <= sort_r + KIDX_W'(1);
          if (sort_r == KIDX_W'(NKEYS - 1)) begin
            sort_r     <= '0;
            send_idx_r <= '0;
            state_r    <= ST_SEND;
          end
        end
        ST_SEND: begin
          vld_o_r    <= 1'b1;
          sof_o_r    <= (send_idx_r == '0);
          eof_o_r    <= (send_idx_r == cnt_r - CNT_W'(1));
          dout_r     <= send_word_s;
          send_idx_r <= send_idx_r + CNT_W'(1);
          if (send_idx_r == cnt_r - CNT_W'(1)) begin
            for (int i = 0; i < NKEYS; i++) keys_r[i] <= '1;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign vld_o    = vld_o_r;
  assign sof_o    = sof_o_r;
  assign eof_o    = eof_o_r;
  assign dout     = dout_r;
  assign busy     = busy_r;
  assign drop_cnt = drop_r;
  assign err      = err_r;

endmodule

// File: tb/tb_axi_stream_frame_sorter.sv
// Scoreboard bench for axi_stream_frame_sorter: a reference sort model predicts
// each output frame; a negedge monitor compares every emitted word.
module tb_axi_stream_frame_sorter;

  localparam int DW = 64;
  localparam int KW = 16;
  localparam int MW = 4;
  localparam int NK = MW * DW / KW;
  localparam int LN = DW / KW;

  typedef logic [DW-1:0] word_q_t[$];
  typedef struct packed {
    logic [DW-1:0] d;
    logic          s;
    logic          e;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          vld, sof, eof;
  logic [DW-1:0] din;
  logic          vld_o, sof_o, eof_o, busy, err;
  logic [DW-1:0] dout;
  logic [7:0]    drop_cnt;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_drop = 0;

  axi_stream_frame_sorter #(.DATA_WIDTH(DW), .KEY_WIDTH(KW), .MAX_WORDS(MW)) dut (
    .clk(clk), .rst(rst), .vld(vld), .sof(sof), .eof(eof), .din(din),
    .vld_o(vld_o), .sof_o(sof_o), .eof_o(eof_o), .dout(dout),
    .busy(busy), .drop_cnt(drop_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: pad with all-ones keys, selection sort, keep the first len words.
  task automatic push_expected(input word_q_t w);
    logic [KW-1:0] k [NK];
    logic [KW-1:0] t;
    logic [DW-1:0] wd;
    exp_t          e;
    for (int i = 0; i < NK; i++) k[i] = '1;
    for (int i = 0; i < w.size(); i++)
      for (int j = 0; j < LN; j++) begin
        wd = w[i];
        k[i*LN+j] = wd[j*KW +: KW];
      end
    for (int i = 0; i < NK; i++)
      for (int j = i + 1; j < NK; j++)
        if (k[j] < k[i]) begin t = k[i]; k[i] = k[j]; k[j] = t; end
    for (int i = 0; i < w.size(); i++) begin
      for (int j = 0; j < LN; j++) e.d[j*KW +: KW] = k[i*LN+j];
      e.s = (i == 0);
      e.e = (i == w.size() - 1);
      sb.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [DW-1:0] d, input logic s, input logic e);
    vld = 1'b1; sof = s; eof = e; din = d;
    tick();
    vld = 1'b0; sof = 1'b0; eof = 1'b0; din = '0;
  endtask

  task automatic send_frame(input word_q_t w, input int gap);
    for (int i = 0; i < w.size(); i++) begin
      drive(w[i], i == 0, i == w.size() - 1);
      if (gap > 0 && i != w.size() - 1) repeat ($urandom_range(0, gap)) tick();
    end
    push_expected(w);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((busy || sb.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check({tag, "_timeout"}, 64'd1, 64'd0);
    tick();
  endtask

  // Output monitor: every valid word must match the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (vld_o) begin
      if (sb.size() == 0) begin
        check("unexpected_out", dout, 64'd0);
      end else begin
        e = sb.pop_front();
        check("out_data", dout, e.d);
        check("out_sof", {63'd0, sof_o}, {63'd0, e.s});
        check("out_eof", {63'd0, eof_o}, {63'd0, e.e});
      end
    end else begin
      check("idle_dout", dout, 64'd0);
    end
  end

  initial begin
    word_q_t w;
    rst = 1'b0; vld = 1'b0; sof = 1'b0; eof = 1'b0; din = '0;
    repeat (3) tick();
    check("rst_vld_o", {63'd0, vld_o}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_drop", {56'd0, drop_cnt}, 64'd0);
    rst = 1'b1;
    tick();

    // 1-word frame, exact latency, and a sof in the final SEND cycle
    w = '{64'h0001_0002_0003_0004};
    drive(w[0], 1'b1, 1'b1);
    push_expected(w);
    check("t1_busy", {63'd0, busy}, 64'd1);
    repeat (16) tick();
    check("t1_not_yet", {63'd0, vld_o}, 64'd0);
    drive(64'h1111_2222_3333_4444, 1'b1, 1'b1);
    exp_drop++;
    check("t1_first_out", {63'd0, vld_o}, 64'd1);
    check("t1_word", dout, 64'h0004_0003_0002_0001);
    check("t1_sofeof", {62'd0, sof_o, eof_o}, 64'd3);
    wait_done("t1");
    check("t1_drop", {56'd0, drop_cnt}, 64'(exp_drop));

    // 4-word frame
    w = '{64'h0002_3332_3141_0004, 64'hFFFF_FF35_000F_0040,
          64'hFFFF_FFFF_FFFF_0002, 64'h3035_4100_04FF_FFFF};
    send_frame(w, 0);
    wait_done("t2");

    // frame arriving 3 cycles into SORT is dropped
    w = '{64'h0009_0008_0007_0006, 64'h0005_0004_0003_0002};
    send_frame(w, 0);
    repeat (2) tick();
    drive(64'h0000_0000_0000_0001, 1'b1, 1'b0);
    drive(64'h0000_0000_0000_0002, 1'b0, 1'b1);
    exp_drop++;
    wait_done("t3");
    check("t3_drop", {56'd0, drop_cnt}, 64'(exp_drop));

    // 5-word overflow, then a legal frame
    for (int i = 0; i < 4; i++) drive(64'(i + 10), i == 0, 1'b0);
    check("t4_err_pre", {63'd0, err}, 64'd0);
    drive(64'd99, 1'b0, 1'b1);
    check("t4_err", {63'd0, err}, 64'd1);
    tick();
    check("t4_err_clr", {63'd0, err}, 64'd0);
    check("t4_busy", {63'd0, busy}, 64'd0);
    w = '{64'h8000_7000_6000_5000, 64'h0100_0200_0300_0400, 64'h0005_0005_0005_0005};
    send_frame(w, 0);
    wait_done("t4");

    // sof restart after 2 words
    drive(64'h0000_0000_0000_0000, 1'b1, 1'b0);
    drive(64'h0000_0000_0000_0001, 1'b0, 1'b0);
    w = '{64'hABCD_0123_4567_0042, 64'h0010_0020_0030_0040, 64'h7777_0001_FFFF_0002};
    drive(w[0], 1'b1, 1'b0);
    check("t5_err", {63'd0, err}, 64'd1);
    drive(w[1], 1'b0, 1'b0);
    check("t5_err_clr", {63'd0, err}, 64'd0);
    drive(w[2], 1'b0, 1'b1);
    push_expected(w);
    wait_done("t5");

    // random frames with idle gaps between words
    for (int f = 0; f < 4; f++) begin
      w.delete();
      for (int i = 0; i < $urandom_range(1, MW); i++) w.push_back({$urandom, $urandom});
      send_frame(w, 2);
      wait_done("rand");
    end

    // reset during SEND word 2 of 4
    w = '{64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005,
          64'h000C_000B_000A_0009, 64'h0010_000F_000E_000D};
    send_frame(w, 0);
    for (int n = 0; n < 40 && !vld_o; n++) tick();
    check("t6_sending", {63'd0, vld_o}, 64'd1);
    tick();
    rst = 1'b0;
    tick();
    sb.delete();
    exp_drop = 0;
    check("t6_vld_o", {63'd0, vld_o}, 64'd0);
    check("t6_dout", dout, 64'd0);
    check("t6_busy", {63'd0, busy}, 64'd0);
    check("t6_drop", {56'd0, drop_cnt}, 64'(exp_drop));
    rst = 1'b1;
    tick();
    w = '{64'h0003_0001_0004_0002};
    send_frame(w, 0);
    wait_done("t6_after");

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
